// File: rtl/adder_mult_sequencer.sv
// Iterative unsigned WIDTH x WIDTH -> 2*WIDTH shift-add multiplier that time-shares
// an external ripple-carry adder, one adder pass per clock.
module adder_mult_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic [WIDTH-1:0]   add_a,
    output logic [WIDTH-1:0]   add_b,
    output logic               add_cin,
    input  logic [WIDTH-1:0]   add_result
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   add_a_q, add_a_d;
    logic [WIDTH-1:0]   add_b_q, add_b_d;
    logic               carry_s;
    logic [2*WIDTH-1:0] shifted_s;

    // The adder exposes no carry-out, so rebuild it from the operand and sum MSBs.
    assign carry_s = (add_a_q[WIDTH-1] & add_b_q[WIDTH-1]) |
                     ((add_a_q[WIDTH-1] ^ add_b_q[WIDTH-1]) & ~add_result[WIDTH-1]);
    assign shifted_s = {carry_s, add_result, q_q[WIDTH-1:1]};

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        acc_d     = acc_q;
        q_d       = q_q;
        count_d   = count_q;
        product_d = product_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    m_d     = op_a;
                    q_d     = op_b;
                    acc_d   = {WIDTH{1'b0}};
                    count_d = {CNT_W{1'b0}};
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                {acc_d, q_d} = shifted_s;
                count_d      = count_q + CNT_W'(1);
                if (count_q == CNT_W'(WIDTH - 1)) begin
                    product_d = shifted_s;
                    state_d   = ST_DONE;
                end else begin
                    state_d   = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
        // Adder operands are registered one cycle ahead so the adder sees ACC and Q[0]?M in RUN.
        if (state_d == ST_RUN) begin
            add_a_d = acc_d;
            add_b_d = q_d[0] ? m_d : {WIDTH{1'b0}};
        end else begin
            add_a_d = {WIDTH{1'b0}};
            add_b_d = {WIDTH{1'b0}};
        end
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            m_q       <= {WIDTH{1'b0}};
            acc_q     <= {WIDTH{1'b0}};
            q_q       <= {WIDTH{1'b0}};
            count_q   <= {CNT_W{1'b0}};
            product_q <= {(2*WIDTH){1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            add_a_q   <= {WIDTH{1'b0}};
            add_b_q   <= {WIDTH{1'b0}};
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            count_q   <= count_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            add_a_q   <= add_a_d;
            add_b_q   <= add_b_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;
    assign add_a   = add_a_q;
    assign add_b   = add_b_q;
    assign add_cin = 1'b0;

endmodule

// File: tb/tb_adder_mult_sequencer.sv
// Randomized and directed bench for adder_mult_sequencer against a behavioural
// product/timing model; the external adder is modelled with plain addition.
module tb_adder_mult_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic        busy, done, add_cin;
    logic [63:0] product;
    logic [31:0] add_a, add_b, add_result;

    int n_checks = 0;
    int n_errors = 0;

    adder_mult_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
        .busy(busy), .done(done), .product(product),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_result(add_result)
    );

    assign add_result = add_a + add_b + {31'd0, add_cin};

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 multiplying (k iterations done), 2 result cycle.
    int          m_phase = 0;
    int          m_k = 0;
    logic [31:0] m_a = 32'd0;
    logic [31:0] m_b = 32'd0;
    logic [63:0] m_prod = 64'd0;

    // High half of the partial product after k iterations: (a * (b mod 2^k)) >> k.
    function automatic logic [31:0] exp_acc(input logic [31:0] a, input logic [31:0] b, input int k);
        logic [63:0] mask;
        logic [63:0] part;
        mask = (64'd1 << k) - 64'd1;
        part = {32'd0, a} * ({32'd0, b} & mask);
        return 32'(part >> k);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_k     <= 0;
            m_a     <= 32'd0;
            m_b     <= 32'd0;
            m_prod  <= 64'd0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_a     <= op_a;
                    m_b     <= op_b;
                    m_k     <= 0;
                    m_phase <= 1;
                end
                1: begin
                    m_k <= m_k + 1;
                    if (m_k == 31) begin
                        m_prod  <= {32'd0, m_a} * {32'd0, m_b};
                        m_phase <= 2;
                    end
                end
                default: m_phase <= 0;
            endcase
        end
    end

    // Cycle-by-cycle comparison against the model on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy", 64'(busy), 64'(m_phase != 0));
            chk("done", 64'(done), 64'(m_phase == 2));
            chk("product", product, m_prod);
            chk("add_a", 64'(add_a), (m_phase == 1) ? 64'(exp_acc(m_a, m_b, m_k)) : 64'd0);
            chk("add_b", 64'(add_b), (m_phase == 1 && m_b[m_k[4:0]]) ? 64'(m_a) : 64'd0);
            chk("add_cin", 64'(add_cin), 64'd0);
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        start = 1'b1; op_a = a; op_b = b;
        @(posedge clk); #1;
        start = 1'b0; op_a = $urandom; op_b = $urandom;
    endtask

    // Counts rising edges until done is seen; 0 means the bound expired.
    task automatic wait_done(output int edges);
        edges = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (done) begin
                edges = i;
                break;
            end
        end
        if (edges == 0) chk("done_timeout", 64'd0, 64'd1);
    endtask

    // done rises after the 32nd edge following the accepting edge.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input string name);
        int e;
        issue(a, b);
        wait_done(e);
        chk({name, "_latency"}, 64'(e), 64'd32);
        chk(name, product, exp);
    endtask

    initial begin
        int e, e2, pulses;
        logic [31:0] ra, rb;
        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_product", product, 64'd0);
        chk("rst_add_a", 64'(add_a), 64'd0);
        @(negedge clk); rst_n = 1'b1;

        run_op(32'd3, 32'd5, 64'h0F, "basic");
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, "max");
        run_op(32'd0, 32'h12345678, 64'd0, "zero");
        run_op(32'd1, 32'h80000000, 64'h00000000_80000000, "identity");

        // Reset during RUN aborts and clears everything at once.
        issue(32'd7, 32'd9);
        repeat (10) @(posedge clk);
        #2; rst_n = 1'b0; #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_product", product, 64'd0);
        chk("midrst_add_a", 64'(add_a), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        run_op(32'd2, 32'd3, 64'd6, "after_rst");

        // start pulse while busy is ignored.
        issue(32'd6, 32'd7);
        repeat (5) @(posedge clk);
        #1; start = 1'b1; op_a = 32'd9; op_b = 32'd9;
        @(posedge clk); #1; start = 1'b0;
        pulses = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (done) begin
                pulses++;
                if (pulses == 1) chk("busy_ignore", product, 64'd42);
            end
        end
        chk("busy_pulses", 64'(pulses), 64'd1);
        chk("busy_dropped", 64'(busy), 64'd0);

        // Back-to-back with start held high.
        @(posedge clk); #1;
        start = 1'b1; op_a = 32'd10; op_b = 32'd10;
        wait_done(e);
        chk("b2b_first", product, 64'd100);
        op_a = 32'd11; op_b = 32'd11;
        wait_done(e2);
        chk("b2b_interval", 64'(e2), 64'd34);
        chk("b2b_second", product, 64'd121);
        start = 1'b0;

        // Randomized operands, mixing in corner values.
        for (int n = 0; n < 25; n++) begin
            case ($urandom_range(0, 3))
                0: ra = 32'hFFFFFFFF;
                1: ra = $urandom_range(0, 15);
                default: ra = $urandom;
            endcase
            rb = ($urandom_range(0, 4) == 0) ? 32'h80000001 : $urandom;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            run_op(ra, rb, {32'd0, ra} * {32'd0, rb}, "random");
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
